// File: rtl/hub75_scan_driver.sv
// HUB75 scan driver: fetches pixel words, shifts one BCM bit-plane per row pair,
// then latches it and lights the panel for a binary-weighted number of cycles.
module hub75_scan_driver #(
   parameter int unsigned hpixel_p     = 64,
   parameter int unsigned vpixel_p     = 64,
   parameter int unsigned bpp_p        = 8,
   parameter int unsigned segments_p   = 2,
   parameter int unsigned on_time_p    = 4,
   localparam int unsigned rps_p        = vpixel_p / segments_p,
   localparam int unsigned addr_width_p = $clog2(hpixel_p * vpixel_p),
   localparam int unsigned row_width_p  = $clog2(rps_p)
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              i_en,
   output logic [addr_width_p-1:0]           o_rd_addr,
   input  logic [segments_p*3*bpp_p-1:0]     i_rd_data,
   output logic [segments_p-1:0]             o_r,
   output logic [segments_p-1:0]             o_g,
   output logic [segments_p-1:0]             o_b,
   output logic                              o_clk,
   output logic                              o_lat,
   output logic                              o_oe_n,
   output logic [row_width_p-1:0]            o_addr,
   output logic                              o_frame_done
);

   localparam int unsigned shift_len_p   = 2 * hpixel_p + 2;
   localparam int unsigned disp_max_p    = on_time_p << (bpp_p - 1);
   localparam int unsigned cnt_max_p     = (shift_len_p > disp_max_p) ? shift_len_p : disp_max_p;
   localparam int unsigned cnt_width_p   = $clog2(cnt_max_p + 1);
   localparam int unsigned plane_width_p = (bpp_p > 1) ? $clog2(bpp_p) : 1;

   typedef enum logic [1:0] {IDLE, SHIFT, LATCH, DISPLAY} state_e;

   state_e                     state_q, state_d;
   logic [cnt_width_p-1:0]     cnt_q, cnt_d;
   logic [row_width_p-1:0]     row_q, row_d;
   logic [plane_width_p-1:0]   plane_q, plane_d;
   logic                       frame_end_c;
   logic [cnt_width_p-1:0]     disp_last_c;
   logic [cnt_width_p-1:0]     col_c;

   logic [addr_width_p-1:0]    rd_addr_q, rd_addr_d;
   logic [segments_p-1:0]      r_q, r_d, g_q, g_d, b_q, b_d;
   logic                       sclk_q, sclk_d;
   logic                       lat_q, lat_d;
   logic                       oe_n_q, oe_n_d;
   logic [row_width_p-1:0]     addr_q, addr_d;
   logic                       frame_done_q, frame_done_d;

   logic [segments_p-1:0][2:0][bpp_p-1:0] pix_c;
   logic [segments_p-1:0]      plane_r_c, plane_g_c, plane_b_c;

   assign pix_c       = i_rd_data;
   assign disp_last_c = (cnt_width_p'(on_time_p) << plane_q) - cnt_width_p'(1);

   // Current bit-plane of each segment's colour channels
   for (genvar s = 0; s < int'(segments_p); s++) begin : g_seg
      assign plane_r_c[s] = pix_c[s][2][plane_q];
      assign plane_g_c[s] = pix_c[s][1][plane_q];
      assign plane_b_c[s] = pix_c[s][0][plane_q];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         row_q   <= '0;
         plane_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         row_q   <= row_d;
         plane_q <= plane_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      row_d       = row_q;
      plane_d     = plane_q;
      frame_end_c = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (i_en) begin
               state_d = SHIFT;
               cnt_d   = '0;
               row_d   = '0;
               plane_d = '0;
            end
         end
         SHIFT: begin
            if (cnt_q == cnt_width_p'(shift_len_p - 1)) begin
               state_d = LATCH;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + cnt_width_p'(1);
            end
         end
         LATCH: begin
            state_d = DISPLAY;
            cnt_d   = '0;
         end
         DISPLAY: begin
            if (cnt_q == disp_last_c) begin
               cnt_d = '0;
               if (plane_q != plane_width_p'(bpp_p - 1)) begin
                  plane_d = plane_q + plane_width_p'(1);
                  state_d = SHIFT;
               end else begin
                  plane_d = '0;
                  if (row_q != row_width_p'(rps_p - 1)) begin
                     row_d   = row_q + row_width_p'(1);
                     state_d = SHIFT;
                  end else begin
                     // Enable is only honoured at frame boundaries
                     row_d       = '0;
                     frame_end_c = 1'b1;
                     state_d     = i_en ? SHIFT : IDLE;
                  end
               end
            end else begin
               cnt_d = cnt_q + cnt_width_p'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs are computed from the upcoming state so registered pins line up with it
   always_comb begin
      rd_addr_d    = rd_addr_q;
      r_d          = r_q;
      g_d          = g_q;
      b_d          = b_q;
      sclk_d       = 1'b0;
      lat_d        = 1'b0;
      oe_n_d       = 1'b1;
      addr_d       = addr_q;
      frame_done_d = frame_end_c;
      col_c        = ((cnt_d >> 1) > cnt_width_p'(hpixel_p - 1)) ?
                     cnt_width_p'(hpixel_p - 1) : (cnt_d >> 1);

      // Data for column n is on i_rd_data in odd cycle 2n+1; present it for edge n
      if (state_q == SHIFT && cnt_q[0] && cnt_q < cnt_width_p'(2 * hpixel_p)) begin
         r_d = plane_r_c;
         g_d = plane_g_c;
         b_d = plane_b_c;
      end

      unique case (state_d)
         IDLE: begin
            rd_addr_d = '0;
            r_d       = '0;
            g_d       = '0;
            b_d       = '0;
            addr_d    = '0;
         end
         SHIFT: begin
            rd_addr_d = addr_width_p'(row_d) * addr_width_p'(hpixel_p) + addr_width_p'(col_c);
            sclk_d    = cnt_d[0] && (cnt_d >= cnt_width_p'(3));
         end
         LATCH: begin
            lat_d  = 1'b1;
            addr_d = row_d;
         end
         DISPLAY: oe_n_d = 1'b0;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_addr_q    <= '0;
         r_q          <= '0;
         g_q          <= '0;
         b_q          <= '0;
         sclk_q       <= 1'b0;
         lat_q        <= 1'b0;
         oe_n_q       <= 1'b1;
         addr_q       <= '0;
         frame_done_q <= 1'b0;
      end else begin
         rd_addr_q    <= rd_addr_d;
         r_q          <= r_d;
         g_q          <= g_d;
         b_q          <= b_d;
         sclk_q       <= sclk_d;
         lat_q        <= lat_d;
         oe_n_q       <= oe_n_d;
         addr_q       <= addr_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign o_rd_addr    = rd_addr_q;
   assign o_r          = r_q;
   assign o_g          = g_q;
   assign o_b          = b_q;
   assign o_clk        = sclk_q;
   assign o_lat        = lat_q;
   assign o_oe_n       = oe_n_q;
   assign o_addr       = addr_q;
   assign o_frame_done = frame_done_q;

endmodule

// File: tb/tb_hub75_scan_driver.sv
// Scoreboard bench for hub75_scan_driver: expected serial bits are queued per frame
// from a pixel model; a monitor pops them on each panel clock rise.
module tb_hub75_scan_driver;

   localparam int H   = 64;
   localparam int V   = 64;
   localparam int B   = 8;
   localparam int S   = 2;
   localparam int ON  = 4;
   localparam int RPS = V / S;
   localparam int AW  = $clog2(H * V);
   localparam int RW  = $clog2(RPS);
   localparam int DW  = S * 3 * B;

   typedef struct {
      logic [S-1:0] r;
      logic [S-1:0] g;
      logic [S-1:0] b;
      int           row;
      int           plane;
      int           col;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          en;
   logic [AW-1:0] o_rd_addr;
   logic [DW-1:0] rd_data = '0;
   logic [S-1:0]  o_r, o_g, o_b;
   logic          o_clk, o_lat, o_oe_n, o_frame_done;
   logic [RW-1:0] o_addr;

   int            checks = 0;
   int            errors = 0;
   int            cyc = 0;
   int            frame_start_cyc = 0;
   int            frame_len_exp = 0;
   int            pat = 0;
   bit            mon_en = 1'b0;
   int unsigned   mul [3];
   int unsigned   off [S][3];
   exp_t          exp_q [$];

   hub75_scan_driver dut (
      .clk          (clk),
      .rst          (rst),
      .i_en         (en),
      .o_rd_addr    (o_rd_addr),
      .i_rd_data    (rd_data),
      .o_r          (o_r),
      .o_g          (o_g),
      .o_b          (o_b),
      .o_clk        (o_clk),
      .o_lat        (o_lat),
      .o_oe_n       (o_oe_n),
      .o_addr       (o_addr),
      .o_frame_done (o_frame_done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Pixel source: pattern 0 = corner markers, pattern 1 = random address gradient
   function automatic logic [DW-1:0] pix(input int a);
      logic [S-1:0][2:0][B-1:0] v;
      v = '0;
      for (int s = 0; s < S; s++)
         for (int c = 0; c < 3; c++)
            if (pat == 0) begin
               if (a == 0 || (a == H - 1 && c == 2) || (a == (RPS - 1) * H && c == 1) ||
                   (a == RPS * H - 1 && c == 0))
                  v[s][c] = '1;
            end else begin
               v[s][c] = B'(int'(a) * mul[c] + off[s][c]);
            end
      return v;
   endfunction

   // Synchronous read: data for the address seen this cycle appears next cycle
   always @(posedge clk) rd_data <= pix(int'(o_rd_addr));

   task automatic chk(input string name, input longint got, input longint want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0d, want %0d", name, cyc, got, want);
      end
   endtask

   task automatic chk_reset(input string name);
      chk(name, {o_rd_addr, o_r, o_g, o_b, o_clk, o_lat, o_oe_n, o_addr, o_frame_done},
          {{AW{1'b0}}, {(3 * S){1'b0}}, 1'b0, 1'b0, 1'b1, {RW{1'b0}}, 1'b0});
   endtask

   task automatic push_frame();
      for (int row = 0; row < RPS; row++)
         for (int pl = 0; pl < B; pl++)
            for (int col = 0; col < H; col++) begin
               exp_t e;
               logic [S-1:0][2:0][B-1:0] pv;
               pv = pix(row * H + col);
               for (int s = 0; s < S; s++) begin
                  e.r[s] = pv[s][2][pl];
                  e.g[s] = pv[s][1][pl];
                  e.b[s] = pv[s][0][pl];
               end
               e.row   = row;
               e.plane = pl;
               e.col   = col;
               exp_q.push_back(e);
            end
   endtask

   // Monitor: serial data, latch/row sequence, BCM on-time and frame period
   logic          prev_clk, prev_oe_n;
   logic [RW-1:0] prev_addr;
   logic [3*S-1:0] prev_rgb;
   int            rises, oe_cnt, lat_idx, cur_plane;

   always @(negedge clk) begin
      if (rst || !mon_en) begin
         prev_clk  = 1'b0;
         prev_oe_n = 1'b1;
         prev_addr = '0;
         prev_rgb  = '0;
         rises     = 0;
         oe_cnt    = 0;
         lat_idx   = 0;
         cur_plane = 0;
      end else begin
         if (o_clk && !prev_clk) begin
            rises++;
            chk("data_stable", {o_r, o_g, o_b}, prev_rgb);
            if (exp_q.size() == 0) begin
               chk("unexpected_sclk_rise", 1, 0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               checks++;
               if ({o_r, o_g, o_b} != {e.r, e.g, e.b}) begin
                  errors++;
                  $display("FAIL serial_bits row=%0d plane=%0d col=%0d: got r=%b g=%b b=%b, want r=%b g=%b b=%b",
                           e.row, e.plane, e.col, o_r, o_g, o_b, e.r, e.g, e.b);
               end
            end
         end
         if (!o_oe_n) begin
            oe_cnt++;
         end else if (!prev_oe_n) begin
            chk("display_cycles", oe_cnt, ON << cur_plane);
            oe_cnt = 0;
         end
         if (o_lat) begin
            chk("rises_per_latch", rises, H);
            chk("latch_row", o_addr, lat_idx / B);
            chk("latch_oe_n", o_oe_n, 1);
            cur_plane = lat_idx % B;
            rises     = 0;
            lat_idx++;
         end
         if (o_addr != prev_addr)
            chk("row_change_outside_latch", o_lat || o_frame_done, 1);
         if (o_frame_done) begin
            chk("frame_period", cyc, frame_start_cyc + frame_len_exp);
            chk("latches_per_frame", lat_idx, RPS * B);
            lat_idx = 0;
         end
         prev_clk  = o_clk;
         prev_oe_n = o_oe_n;
         prev_addr = o_addr;
         prev_rgb  = {o_r, o_g, o_b};
      end
   end

   initial begin
      bit found;
      rst = 1'b1;
      en  = 1'b0;
      for (int c = 0; c < 3; c++) begin
         mul[c] = $urandom | 32'd1;
         for (int s = 0; s < S; s++) off[s][c] = $urandom;
      end
      for (int b = 0; b < B; b++) frame_len_exp += 2 * H + 2 + 1 + (ON << b);
      frame_len_exp *= RPS;

      repeat (3) @(negedge clk);
      chk_reset("reset_values");
      rst = 1'b0;
      repeat (20) begin
         @(negedge clk);
         chk_reset("idle_hold_pre");
      end

      // Corner pattern frame; enable dropped at row 10, frame must still complete
      pat = 0;
      push_frame();
      mon_en = 1'b1;
      frame_start_cyc = cyc + 1;
      en = 1'b1;
      found = 1'b0;
      for (int i = 0; i < 30000 && !found; i++) begin
         @(negedge clk);
         if (o_lat && o_addr == RW'(10)) found = 1'b1;
      end
      chk("reach_row10", found, 1);
      en = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 50000 && !found; i++) begin
         @(negedge clk);
         if (o_frame_done) found = 1'b1;
      end
      chk("frame_done_seen", found, 1);
      repeat (20) begin
         @(negedge clk);
         chk_reset("idle_after_drop");
      end
      chk("queue_drained", exp_q.size(), 0);

      // Random gradient frame, interrupted by an asynchronous reset mid-display
      pat = 1;
      push_frame();
      frame_start_cyc = cyc + 1;
      en = 1'b1;
      @(negedge clk);
      chk("first_rd_addr", o_rd_addr, 0);
      found = 1'b0;
      for (int i = 0; i < 25000 && !found; i++) begin
         @(negedge clk);
         if (o_lat && o_addr == RW'(10)) found = 1'b1;
      end
      chk("reach_row10_grad", found, 1);
      found = 1'b0;
      for (int i = 0; i < 300 && !found; i++) begin
         @(negedge clk);
         if (!o_oe_n) found = 1'b1;
      end
      chk("reach_display", found, 1);
      repeat (2) @(negedge clk);
      #2;
      mon_en = 1'b0;
      rst = 1'b1;
      #1;
      chk_reset("async_reset");
      exp_q.delete();
      en = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      repeat (100) begin
         @(negedge clk);
         chk_reset("idle_hold_post");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
